// File: rtl/sysid_pkg.sv
// rtl/sysid_pkg.sv - shared constants and parameter checks for the sysid/uptime slave
//
// Purpose: word addresses of the register map, CONTROL bit positions and the
// legal-range checks applied to the top-level parameters.
// Ports: none (package).
package sysid_pkg;

  localparam logic [2:0] SYSID_ADDR_ID      = 3'd0;
  localparam logic [2:0] SYSID_ADDR_TS      = 3'd1;
  localparam logic [2:0] SYSID_ADDR_CAPS    = 3'd2;
  localparam logic [2:0] SYSID_ADDR_SCRATCH = 3'd3;
  localparam logic [2:0] SYSID_ADDR_UP_LO   = 3'd4;
  localparam logic [2:0] SYSID_ADDR_UP_HI   = 3'd5;
  localparam logic [2:0] SYSID_ADDR_CTRL    = 3'd6;

  localparam int SYSID_CTRL_CLR = 0;

  function automatic bit sysid_data_width_ok(input int w);
    return (w == 32) || (w == 64);
  endfunction

  function automatic bit sysid_read_latency_ok(input int l);
    return (l >= 1) && (l <= 3);
  endfunction

endpackage

// File: rtl/sysid_rd_pipe.sv
// rtl/sysid_rd_pipe.sv - fixed-depth valid/data shift pipeline for read responses
//
// Purpose: delays each captured read response by DEPTH cycles, one entry per
// cycle, so back-to-back reads come out back-to-back and in order.
// Ports:
//   clock     in   rising-edge clock
//   clear     in   synchronous clear; drops every entry in flight
//   in_valid  in   a response enters the pipe this cycle
//   in_data   in   response data captured with in_valid
//   out_valid out  response leaving the pipe
//   out_data  out  response data, forced to 0 when out_valid is 0
module sysid_rd_pipe #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] vld;
  logic [WIDTH-1:0] dat [DEPTH];

  always_ff @(posedge clock) begin
    if (clear) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) dat[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      dat[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        dat[i] <= dat[i-1];
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_data  = vld[DEPTH-1] ? dat[DEPTH-1] : '0;

endmodule

// File: rtl/sysid_uptime_regs.sv
// rtl/sysid_uptime_regs.sv - system-id slave with scratch register and uptime counter
//
// Purpose: read-only build identification words, a scratch register, a
// free-running uptime counter with an atomic LO/HI snapshot, and a
// fixed-latency pipelined read path.
// Ports:
//   clock          in   rising-edge clock
//   reset          in   synchronous, active-high reset
//   address        in   word address (3 bits)
//   read           in   read strobe, accepted every cycle
//   write          in   write strobe, accepted every cycle
//   writedata      in   write data
//   readdata       out  read data, 0 unless readdatavalid
//   readdatavalid  out  one pulse per accepted read, READ_LATENCY cycles later
module sysid_uptime_regs
  import sysid_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID    = 32'h0,
  parameter logic [31:0] TIMESTAMP    = 32'd0,
  parameter logic [31:0] CAPS         = 32'h0,
  parameter int          DATA_WIDTH   = 32,
  parameter int          UPTIME_WIDTH = 64,
  parameter int          READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  read,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] writedata,
  output logic [DATA_WIDTH-1:0] readdata,
  output logic                  readdatavalid
);

  localparam int EXT_WIDTH = 2 * DATA_WIDTH;

  if (!sysid_data_width_ok(DATA_WIDTH)) begin : g_bad_data_width
    $error("sysid_uptime_regs: DATA_WIDTH must be 32 or 64");
  end
  if (!sysid_read_latency_ok(READ_LATENCY)) begin : g_bad_read_latency
    $error("sysid_uptime_regs: READ_LATENCY must be 1..3");
  end
  if (UPTIME_WIDTH < 1 || UPTIME_WIDTH > EXT_WIDTH) begin : g_bad_uptime_width
    $error("sysid_uptime_regs: UPTIME_WIDTH must be 1..2*DATA_WIDTH");
  end

  logic [UPTIME_WIDTH-1:0] uptime;
  logic [EXT_WIDTH-1:0]    uptime_ext;
  logic [DATA_WIDTH-1:0]   scratch;
  logic [DATA_WIDTH-1:0]   shadow;
  logic [DATA_WIDTH-1:0]   rd_mux;
  logic                    clr_hit;

  assign clr_hit = write && (address == SYSID_ADDR_CTRL) && writedata[SYSID_CTRL_CLR];

  // Counter zero-extended to two bus words so LO/HI slicing is uniform
  // regardless of UPTIME_WIDTH.
  always_comb begin
    uptime_ext = '0;
    uptime_ext[UPTIME_WIDTH-1:0] = uptime;
  end

  always_ff @(posedge clock) begin
    if (reset || clr_hit) uptime <= '0;
    else                  uptime <= uptime + UPTIME_WIDTH'(1);
  end

  always_ff @(posedge clock) begin
    if (reset)                                      scratch <= '0;
    else if (write && address == SYSID_ADDR_SCRATCH) scratch <= writedata;
  end

  // HI half is latched in the same cycle LO is sampled, so a LO-then-HI
  // read pair always describes one counter value.
  always_ff @(posedge clock) begin
    if (reset)                                    shadow <= '0;
    else if (read && address == SYSID_ADDR_UP_LO) shadow <= uptime_ext[EXT_WIDTH-1:DATA_WIDTH];
  end

  // Mux sees pre-write register values, so a same-cycle read/write of one
  // address returns the old contents.
  always_comb begin
    rd_mux = '0;
    case (address)
      SYSID_ADDR_ID:      rd_mux = DATA_WIDTH'(SYSTEM_ID);
      SYSID_ADDR_TS:      rd_mux = DATA_WIDTH'(TIMESTAMP);
      SYSID_ADDR_CAPS:    rd_mux = DATA_WIDTH'(CAPS);
      SYSID_ADDR_SCRATCH: rd_mux = scratch;
      SYSID_ADDR_UP_LO:   rd_mux = uptime_ext[DATA_WIDTH-1:0];
      SYSID_ADDR_UP_HI:   rd_mux = shadow;
      default:            rd_mux = '0;
    endcase
  end

  sysid_rd_pipe #(
    .DEPTH (READ_LATENCY),
    .WIDTH (DATA_WIDTH)
  ) u_rd_pipe (
    .clock     (clock),
    .clear     (reset),
    .in_valid  (read),
    .in_data   (rd_mux),
    .out_valid (readdatavalid),
    .out_data  (readdata)
  );

endmodule

// File: tb/tb_sysid_uptime_regs.sv
// tb/tb_sysid_uptime_regs.sv - scoreboard bench for sysid_uptime_regs over three configurations
//
// Purpose: drives three instances (latency 1/2/3, uptime width 64/4/64) with
// directed reads and writes; expected responses are queued with the cycle
// they must appear in and checked when readdatavalid fires.
// Ports: none (testbench).
module tb_sysid_uptime_regs;

  localparam logic [31:0] ID0 = 32'hCAFE0001, TS0 = 32'd1626704057, CP0 = 32'h5;
  localparam logic [31:0] ID1 = 32'hB00C0002, TS1 = 32'd1700000000, CP1 = 32'hA;
  localparam logic [31:0] ID2 = 32'h5EED0003, TS2 = 32'd1234567890, CP2 = 32'h3;

  typedef struct {
    int          dut;
    int          cyc;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst   [3];
  logic [2:0]  addr  [3];
  logic        rd    [3];
  logic        wr    [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic        rdv   [3];

  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sysid_uptime_regs #(.SYSTEM_ID(ID0), .TIMESTAMP(TS0), .CAPS(CP0),
                      .DATA_WIDTH(32), .UPTIME_WIDTH(64), .READ_LATENCY(1)) dut0 (
    .clock(clk), .reset(rst[0]), .address(addr[0]), .read(rd[0]), .write(wr[0]),
    .writedata(wdata[0]), .readdata(rdata[0]), .readdatavalid(rdv[0]));

  sysid_uptime_regs #(.SYSTEM_ID(ID1), .TIMESTAMP(TS1), .CAPS(CP1),
                      .DATA_WIDTH(32), .UPTIME_WIDTH(4), .READ_LATENCY(2)) dut1 (
    .clock(clk), .reset(rst[1]), .address(addr[1]), .read(rd[1]), .write(wr[1]),
    .writedata(wdata[1]), .readdata(rdata[1]), .readdatavalid(rdv[1]));

  sysid_uptime_regs #(.SYSTEM_ID(ID2), .TIMESTAMP(TS2), .CAPS(CP2),
                      .DATA_WIDTH(32), .UPTIME_WIDTH(64), .READ_LATENCY(3)) dut2 (
    .clock(clk), .reset(rst[2]), .address(addr[2]), .read(rd[2]), .write(wr[2]),
    .writedata(wdata[2]), .readdata(rdata[2]), .readdatavalid(rdv[2]));

  function automatic int lat(input int d);
    case (d)
      0:       return 1;
      1:       return 2;
      default: return 3;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rd_issue(input int d, input logic [2:0] a, input logic [31:0] e);
    exp_t x;
    x.dut  = d;
    x.cyc  = cyc + lat(d);
    x.data = e;
    sb.push_back(x);
    rd[d]   = 1'b1;
    addr[d] = a;
    step();
    rd[d]   = 1'b0;
  endtask

  task automatic wr_issue(input int d, input logic [2:0] a, input logic [31:0] v);
    wr[d]    = 1'b1;
    addr[d]  = a;
    wdata[d] = v;
    step();
    wr[d]    = 1'b0;
  endtask

  // Leaves the bench in the first cycle with reset low (uptime k = 0).
  task automatic do_reset(input int d);
    rst[d] = 1'b1;
    idle(2);
    rst[d] = 1'b0;
  endtask

  task automatic sweep(input int d, input logic [31:0] id, input logic [31:0] ts,
                       input logic [31:0] cp, input logic [31:0] scr);
    rd_issue(d, 3'd0, id);
    rd_issue(d, 3'd1, ts);
    rd_issue(d, 3'd2, cp);
    rd_issue(d, 3'd3, scr);
    rd_issue(d, 3'd7, 32'h0);
  endtask

  // Response monitor: every valid must match the oldest pending entry for
  // that instance, in data and in cycle; idle cycles must show zero data.
  always @(negedge clk) begin
    int idx;
    for (int d = 0; d < 3; d++) begin
      if (rdv[d] === 1'b1) begin
        idx = -1;
        foreach (sb[i]) if (idx < 0 && sb[i].dut == d) idx = i;
        tests++;
        assert (idx >= 0) else begin
          fails++;
          $error("FAIL unexpected_valid dut%0d cycle %0d: readdatavalid=1, required 0", d, cyc);
        end
        if (idx >= 0) begin
          tests++;
          assert (rdata[d] === sb[idx].data) else begin
            fails++;
            $error("FAIL rd_data dut%0d cycle %0d: got %h, required %h", d, cyc, rdata[d], sb[idx].data);
          end
          tests++;
          assert (cyc === sb[idx].cyc) else begin
            fails++;
            $error("FAIL rd_cycle dut%0d: valid at cycle %0d, required cycle %0d", d, cyc, sb[idx].cyc);
          end
          sb.delete(idx);
        end
      end else begin
        tests++;
        assert (rdata[d] === 32'h0 && rdv[d] === 1'b0) else begin
          fails++;
          $error("FAIL idle_zero dut%0d cycle %0d: readdata=%h valid=%b, required 0/0", d, cyc, rdata[d], rdv[d]);
        end
      end
    end
    for (int i = sb.size() - 1; i >= 0; i--) begin
      tests++;
      assert (sb[i].cyc >= cyc) else begin
        fails++;
        $error("FAIL missed_valid dut%0d: no response by cycle %0d, required at cycle %0d",
               sb[i].dut, cyc, sb[i].cyc);
        sb.delete(i);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish by time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = 3'd0; wdata[d] = 32'h0;
    end
    idle(3);
    for (int d = 0; d < 3; d++) begin
      tests++;
      assert (rdv[d] === 1'b0 && rdata[d] === 32'h0) else begin
        fails++;
        $error("FAIL reset_state dut%0d: valid=%b data=%h, required 0/0", d, rdv[d], rdata[d]);
      end
      rst[d] = 1'b0;
    end

    // Instance 0: identity, scratch, reserved, uptime snapshot.
    rd_issue(0, 3'd3, 32'h0);
    rd_issue(0, 3'd5, 32'h0);
    wr_issue(0, 3'd3, 32'hDEADBEEF);
    rd_issue(0, 3'd3, 32'hDEADBEEF);
    wr_issue(0, 3'd0, 32'h12345678);
    rd_issue(0, 3'd0, ID0);
    rd[0] = 1'b1; wr[0] = 1'b1; addr[0] = 3'd3; wdata[0] = 32'h0BADF00D;
    begin
      exp_t x;
      x.dut = 0; x.cyc = cyc + lat(0); x.data = 32'hDEADBEEF;
      sb.push_back(x);
    end
    step();
    rd[0] = 1'b0; wr[0] = 1'b0;
    wr_issue(0, 3'd7, 32'hFFFFFFFF);
    sweep(0, ID0, TS0, CP0, 32'h0BADF00D);
    idle(4);
    do_reset(0);
    rd_issue(0, 3'd5, 32'h0);
    idle(9);
    rd_issue(0, 3'd4, 32'd10);
    rd_issue(0, 3'd5, 32'h0);
    rd_issue(0, 3'd3, 32'h0);
    idle(4);

    // Instance 1: latency 2, 4-bit counter wrap and clear.
    wr_issue(1, 3'd3, 32'h00C0FFEE);
    sweep(1, ID1, TS1, CP1, 32'h00C0FFEE);
    idle(4);
    do_reset(1);
    idle(17);
    rd_issue(1, 3'd4, 32'd1);
    wr_issue(1, 3'd6, 32'h1);
    idle(1);
    rd_issue(1, 3'd4, 32'd1);
    rd_issue(1, 3'd6, 32'h0);
    rd_issue(1, 3'd5, 32'h0);
    idle(4);

    // Instance 2: latency 3, data in flight, reset mid-pipeline.
    sweep(2, ID2, TS2, CP2, 32'h0);
    wr_issue(2, 3'd3, 32'h00001234);
    rd_issue(2, 3'd3, 32'h00001234);
    wr_issue(2, 3'd3, 32'h00005678);
    rd_issue(2, 3'd3, 32'h00005678);
    idle(5);
    rd[2] = 1'b1; addr[2] = 3'd3;
    step();
    rd[2] = 1'b0;
    rst[2] = 1'b1;
    idle(2);
    rst[2] = 1'b0;
    rd_issue(2, 3'd4, 32'h0);
    rd_issue(2, 3'd3, 32'h0);
    rd_issue(2, 3'd5, 32'h0);
    idle(6);

    tests++;
    assert (sb.size() === 0) else begin
      fails++;
      $error("FAIL drain: %0d responses still pending, required 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
